// File: rtl/pipeline_ctrl_if.sv
// Stall/flush bundle between the hazard/memory sources and the pipeline controller.
// The master side raises requests and consumes enables, flushes and counters.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stall_i;
    logic             PCSrc_E;
    logic             mem_req_M;
    logic             mem_ready_M;
    logic             en_F;
    logic             en_D;
    logic             en_E;
    logic             en_M;
    logic             en_W;
    logic             flush_D;
    logic             flush_E;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output stall_i, PCSrc_E, mem_req_M, mem_ready_M,
        input  en_F, en_D, en_E, en_M, en_W, flush_D, flush_E,
        input  mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  stall_i, PCSrc_E, mem_req_M, mem_ready_M,
        output en_F, en_D, en_E, en_M, en_W, flush_D, flush_E,
        output mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: arbitrates memory freeze, redirect and load-use
// stall into stage enables/flushes, with a memory-wait watchdog and saturating counters.
module pipeline_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic        timeout_reg, timeout_next;

    logic mem_wait;
    logic freeze;
    logic redirect;
    logic load_use;
    logic en_f, en_d, en_e, en_m, en_w;
    logic flush_d, flush_e;
    logic [1:0] cnt_inc;

    assign mem_wait = bus.mem_req_M & ~bus.mem_ready_M;
    // Any state other than RUN/MEM_WAIT (TIMEOUT or an illegal code) holds the pipeline.
    assign freeze   = mem_wait | ((state_reg != ST_RUN) && (state_reg != ST_MEM_WAIT));
    assign redirect = ~freeze & bus.PCSrc_E;
    assign load_use = ~freeze & ~bus.PCSrc_E & bus.stall_i;

    always_comb begin
        en_f    = 1'b1;
        en_d    = 1'b1;
        en_e    = 1'b1;
        en_m    = 1'b1;
        en_w    = 1'b1;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst_n) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (freeze) begin
            {en_f, en_d, en_e, en_m, en_w} = 5'b00000;
        end else if (redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            en_f    = 1'b0;
            en_d    = 1'b0;
            flush_e = 1'b1;
        end
    end

    assign bus.en_F        = en_f;
    assign bus.en_D        = en_d;
    assign bus.en_E        = en_e;
    assign bus.en_M        = en_m;
    assign bus.en_W        = en_w;
    assign bus.flush_D     = flush_d;
    assign bus.flush_E     = flush_e;
    assign bus.mem_timeout = timeout_reg & rst_n;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_wait) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = 16'd1;
                end else begin
                    wait_cnt_next = 16'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_wait) begin
                    if (wait_cnt_reg == 16'(MEM_TIMEOUT)) begin
                        state_next   = ST_TIMEOUT;
                        timeout_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 16'd1;
                    end
                end else begin
                    // Completion or a dropped request both release the pipeline.
                    state_next    = ST_RUN;
                    wait_cnt_next = 16'd0;
                end
            end
            ST_TIMEOUT: begin
                state_next = ST_TIMEOUT;
            end
            default: begin
                state_next    = ST_RUN;
                wait_cnt_next = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= 16'd0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Index 0 counts cycles with the PC held, index 1 counts accepted redirects.
    assign cnt_inc = {redirect, ~en_f};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : cnt_g
            logic [CNT_W-1:0] cnt_reg, cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
                    cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            always_ff @(posedge clk) begin
                if (!rst_n) cnt_reg <= '0;
                else        cnt_reg <= cnt_next;
            end

            if (gi == 0) begin : stall_g
                assign bus.stall_cnt = cnt_reg;
            end else begin : flush_g
                assign bus.flush_cnt = cnt_reg;
            end
        end
    endgenerate
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised plus directed bench for pipeline_ctrl against a behavioural model of
// the priority rules, watchdog and saturating counters.
module tb_pipeline_ctrl;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // ctl vector bit order: en_F en_D en_E en_M en_W flush_D flush_E mem_timeout
    localparam logic [7:0] C_RESET    = 8'b00000110;
    localparam logic [7:0] C_RUN      = 8'b11111000;
    localparam logic [7:0] C_LOADUSE  = 8'b00111010;
    localparam logic [7:0] C_REDIRECT = 8'b11111110;
    localparam logic [7:0] C_FREEZE   = 8'b00000000;
    localparam logic [7:0] C_FROZE_TO = 8'b00000001;

    logic clk = 1'b0;
    logic rst_n;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Behavioural model: consecutive wait length, sticky timeout, counter values.
    bit m_valid  = 1'b0;
    int m_consec = 0;
    bit m_timed  = 1'b0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    function automatic logic [7:0] exp_ctl(input logic r, input logic st, input logic pc,
                                           input logic rq, input logic rd, input bit tmo);
        if (!r)                return C_RESET;
        if (tmo || (rq && !rd)) return {7'b0000000, tmo};
        if (pc)                return C_REDIRECT;
        if (st)                return C_LOADUSE;
        return C_RUN;
    endfunction

    function automatic logic [7:0] dut_ctl();
        return {bus.en_F, bus.en_D, bus.en_E, bus.en_M, bus.en_W,
                bus.flush_D, bus.flush_E, bus.mem_timeout};
    endfunction

    always @(posedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_consec = 0;
            m_timed  = 1'b0;
            m_stall  = 0;
            m_flush  = 0;
        end else if (m_valid) begin
            e = exp_ctl(rst_n, bus.stall_i, bus.PCSrc_E, bus.mem_req_M, bus.mem_ready_M, m_timed);
            if (!e[7] && m_stall < CNT_MAX) m_stall++;
            if (e[2] && m_flush < CNT_MAX)  m_flush++;
            if (!m_timed) begin
                if (bus.mem_req_M && !bus.mem_ready_M) begin
                    m_consec++;
                    if (m_consec > MEM_TIMEOUT) m_timed = 1'b1;
                end else begin
                    m_consec = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("ctl_model", 32'(dut_ctl()),
                  32'(exp_ctl(rst_n, bus.stall_i, bus.PCSrc_E, bus.mem_req_M, bus.mem_ready_M, m_timed)));
            check("stall_cnt_model", 32'(bus.stall_cnt), 32'(m_stall));
            check("flush_cnt_model", 32'(bus.flush_cnt), 32'(m_flush));
        end
    end

    task automatic drive(input logic r, input logic st, input logic pc,
                         input logic rq, input logic rd);
        @(posedge clk);
        #1;
        rst_n           = r;
        bus.stall_i     = st;
        bus.PCSrc_E     = pc;
        bus.mem_req_M   = rq;
        bus.mem_ready_M = rd;
        @(negedge clk);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.stall_i     = 1'b0;
        bus.PCSrc_E     = 1'b0;
        bus.mem_req_M   = 1'b0;
        bus.mem_ready_M = 1'b0;

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("reset_ctl", 32'(dut_ctl()), 32'(C_RESET));
        check("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("reset_flush_cnt", 32'(bus.flush_cnt), 32'd0);

        drive(1, 1, 0, 0, 0);
        check("loaduse_ctl", 32'(dut_ctl()), 32'(C_LOADUSE));
        drive(1, 0, 0, 0, 0);
        check("loaduse_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        check("idle_ctl", 32'(dut_ctl()), 32'(C_RUN));

        drive(1, 1, 1, 0, 0);
        check("redirect_over_stall_ctl", 32'(dut_ctl()), 32'(C_REDIRECT));
        drive(1, 0, 0, 0, 0);
        check("redirect_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        check("redirect_stall_cnt", 32'(bus.stall_cnt), 32'd1);

        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 0);
            check("memwait_freeze_ctl", 32'(dut_ctl()), 32'(C_FREEZE));
        end
        drive(1, 0, 1, 1, 1);
        check("memready_redirect_ctl", 32'(dut_ctl()), 32'(C_REDIRECT));
        check("memwait_stall_cnt", 32'(bus.stall_cnt), 32'd4);
        drive(1, 0, 0, 0, 0);
        check("memwait_back_to_run", 32'(dut_ctl()), 32'(C_RUN));
        check("memwait_flush_cnt", 32'(bus.flush_cnt), 32'd2);

        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 1, 0);
            if (i == 4) check("timeout_not_yet", 32'(dut_ctl()), 32'(C_FREEZE));
            if (i == 5) check("timeout_raised", 32'(dut_ctl()), 32'(C_FROZE_TO));
        end
        check("timeout_stall_cnt", 32'(bus.stall_cnt), 32'd13);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 1, 1);
            check("timeout_stays_frozen", 32'(dut_ctl()), 32'(C_FROZE_TO));
        end
        check("stall_cnt_saturated", 32'(bus.stall_cnt), 32'd15);
        drive(0, 0, 0, 0, 0);
        check("timeout_reset_ctl", 32'(dut_ctl()), 32'(C_RESET));
        drive(1, 0, 0, 0, 0);
        check("timeout_cleared_ctl", 32'(dut_ctl()), 32'(C_RUN));
        check("timeout_cleared_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        check("saturation_stall_cnt", 32'(bus.stall_cnt), 32'd15);
        check("saturation_flush_cnt", 32'(bus.flush_cnt), 32'd0);

        drive(1, 0, 1, 1, 0);
        drive(1, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 0);
        check("midwait_reset_ctl", 32'(dut_ctl()), 32'(C_RESET));
        drive(0, 0, 1, 1, 0);
        check("midwait_reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("midwait_reset_flush_cnt", 32'(bus.flush_cnt), 32'd0);
        drive(1, 0, 0, 0, 0);
        check("midwait_release_ctl", 32'(dut_ctl()), 32'(C_RUN));

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
